// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
//   Game-level sequencer for the snake datapath. It turns VGA frame ticks
//   into body step strobes, filters direction keys, places prey from a
//   10-bit LFSR, counts score and runs the IDLE/INIT/RUN/PAUSE/OVER game
//   state machine.
//
//   Optional feature: define SNAKE_CTRL_SPEEDUP_EN to shorten the step
//   period as the score grows. The period is STEP_FRAMES - score/4, with a
//   floor of 2. Without the macro the period is fixed at STEP_FRAMES.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     start                        level, leaves IDLE/OVER
//     pause                        pulse, toggles RUN/PAUSE
//     key_dir, key_vld             requested direction and its qualifier
//     frame_tick                   one pulse per VGA frame
//     snake_score, body_hit        prey-eaten / self-collision pulses
//     snake_headx, snake_heady     current head cell
//     body_rst, body_enb           reset / enable for the body block
//     body_valid, body_direction   step strobe and committed direction
//     preyx, preyy                 prey cell
//     score, game_won              eaten count, win flag
//     state                        IDLE=0 INIT=1 RUN=2 PAUSE=3 OVER=4
//
//   Handshake: body_valid is a one-cycle strobe with no ready. The body
//   block must take a step on every cycle where body_valid is high, and
//   body_direction is the direction valid for that step.
module snake_game_ctrl #(
   parameter int H_LOGIC_WIDTH = 5,
   parameter int V_LOGIC_WIDTH = 5,
   parameter int H_LOGIC_MAX   = 31,
   parameter int V_LOGIC_MAX   = 23,
   parameter int STEP_FRAMES   = 8,
   parameter int INIT_CYCLES   = 4,
   parameter int SCORE_WIDTH   = 8,
   parameter int SCORE_MAX     = 100
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     pause,
   input  logic [1:0]               key_dir,
   input  logic                     key_vld,
   input  logic                     frame_tick,
   input  logic                     snake_score,
   input  logic                     body_hit,
   input  logic [H_LOGIC_WIDTH-1:0] snake_headx,
   input  logic [V_LOGIC_WIDTH-1:0] snake_heady,
   output logic                     body_rst,
   output logic                     body_enb,
   output logic                     body_valid,
   output logic [1:0]               body_direction,
   output logic [H_LOGIC_WIDTH-1:0] preyx,
   output logic [V_LOGIC_WIDTH-1:0] preyy,
   output logic [SCORE_WIDTH-1:0]   score,
   output logic [2:0]               state,
   output logic                     game_won
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [H_LOGIC_WIDTH-1:0] PREY_X0 = H_LOGIC_WIDTH'(H_LOGIC_MAX / 2 + 4);
   localparam logic [V_LOGIC_WIDTH-1:0] PREY_Y0 = V_LOGIC_WIDTH'(V_LOGIC_MAX / 2);

   state_t                   r_state;
   logic [IW-1:0]            r_init_cnt;
   logic [3:0]               r_step_cnt;
   logic [3:0]               r_period;
   logic [1:0]               r_dir;
   logic [1:0]               r_pend;
   logic [9:0]               r_lfsr;
   logic                     r_body_rst;
   logic                     r_body_enb;
   logic                     r_body_valid;
   logic [H_LOGIC_WIDTH-1:0] r_preyx;
   logic [V_LOGIC_WIDTH-1:0] r_preyy;
   logic [SCORE_WIDTH-1:0]   r_score;
   logic                     r_game_won;

   state_t                   w_state_nxt;
   logic                     w_init_done;
   logic                     w_score_max;
   logic                     w_step_done;
   logic                     w_valid_nxt;
   logic                     w_eat;
   logic                     w_key_ok;
   logic [3:0]               w_period_nxt;
   logic [4:0]               w_raw_y;
   logic [H_LOGIC_WIDTH-1:0] w_cand_x;
   logic [V_LOGIC_WIDTH-1:0] w_cand_y;
   logic [H_LOGIC_WIDTH-1:0] w_new_x;

   assign w_init_done = (r_init_cnt == IW'(INIT_CYCLES - 1));
   assign w_score_max = (r_score == SCORE_WIDTH'(SCORE_MAX));
   assign w_step_done = (r_state == S_RUN) && frame_tick && (r_step_cnt == r_period - 4'd1);
   // A step that completes while the game leaves RUN produces no strobe.
   assign w_valid_nxt = w_step_done && (w_state_nxt == S_RUN);
   assign w_eat       = (r_state == S_RUN) && snake_score;
   // Reversal check is against the committed direction, not the pending one.
   assign w_key_ok    = key_vld && ((r_state == S_RUN) || (r_state == S_PAUSE)) &&
                        ((key_dir ^ r_dir) != 2'b11);

`ifdef SNAKE_CTRL_SPEEDUP_EN
   logic [SCORE_WIDTH-1:0] w_spd;
   assign w_spd = {2'b00, r_score[SCORE_WIDTH-1:2]};
   always_comb begin
      w_period_nxt = 4'd2;
      if (int'(w_spd) + 2 <= STEP_FRAMES) begin
         w_period_nxt = 4'(STEP_FRAMES - int'(w_spd));
      end
   end
`else
   assign w_period_nxt = 4'(STEP_FRAMES);
`endif

   // Prey candidate: y is folded back into the grid, x steps off the head.
   assign w_raw_y  = r_lfsr[4:0];
   assign w_cand_x = H_LOGIC_WIDTH'(r_lfsr[9:5]);
   always_comb begin
      w_cand_y = V_LOGIC_WIDTH'(w_raw_y);
      if (int'(w_raw_y) > V_LOGIC_MAX) begin
         w_cand_y = V_LOGIC_WIDTH'(int'(w_raw_y) - (V_LOGIC_MAX + 1));
      end
      w_new_x = w_cand_x;
      if ((w_cand_x == snake_headx) && (w_cand_y == snake_heady)) begin
         w_new_x = (w_cand_x == H_LOGIC_WIDTH'(H_LOGIC_MAX)) ? '0
                                                             : w_cand_x + H_LOGIC_WIDTH'(1);
      end
   end

   // Next state; body_hit outranks pause, and SCORE_MAX ends the game one
   // cycle after it is reached.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_INIT;
         S_INIT:  if (w_init_done) w_state_nxt = S_RUN;
         S_RUN: begin
            if (body_hit || w_score_max) w_state_nxt = S_OVER;
            else if (pause)              w_state_nxt = S_PAUSE;
         end
         S_PAUSE: if (pause) w_state_nxt = S_RUN;
         S_OVER:  if (start) w_state_nxt = S_INIT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_init_cnt   <= '0;
         r_step_cnt   <= 4'd0;
         r_period     <= 4'(STEP_FRAMES);
         r_dir        <= DIR_RIGHT;
         r_pend       <= DIR_RIGHT;
         r_lfsr       <= 10'h2A5;
         r_body_rst   <= 1'b1;
         r_body_enb   <= 1'b0;
         r_body_valid <= 1'b0;
         r_preyx      <= '0;
         r_preyy      <= '0;
         r_score      <= '0;
         r_game_won   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         // Taps 10,7: maximal-length, so the all-zero state is never reached.
         r_lfsr       <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
         r_body_rst   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_INIT);
         r_body_enb   <= (w_state_nxt == S_RUN);
         r_body_valid <= w_valid_nxt;
         r_init_cnt   <= (r_state == S_INIT) ? r_init_cnt + IW'(1) : '0;

         case (r_state)
            S_INIT: begin
               r_score    <= '0;
               r_dir      <= DIR_RIGHT;
               r_pend     <= DIR_RIGHT;
               r_preyx    <= PREY_X0;
               r_preyy    <= PREY_Y0;
               r_step_cnt <= 4'd0;
               r_period   <= 4'(STEP_FRAMES);
               r_game_won <= 1'b0;
            end
            S_RUN: begin
               if (frame_tick) begin
                  r_step_cnt <= w_step_done ? 4'd0 : r_step_cnt + 4'd1;
               end
               // A new period is only picked up at a step boundary.
               if (w_step_done) r_period <= w_period_nxt;
               if (w_valid_nxt) r_dir <= r_pend;
               if (w_eat) begin
                  if (!w_score_max) r_score <= r_score + SCORE_WIDTH'(1);
                  r_preyx <= w_new_x;
                  r_preyy <= w_cand_y;
               end
               if (w_score_max) r_game_won <= 1'b1;
            end
            default: ;
         endcase

         if (w_key_ok) r_pend <= key_dir;
      end
   end

   assign body_rst       = r_body_rst;
   assign body_enb       = r_body_enb;
   assign body_valid     = r_body_valid;
   assign body_direction = r_dir;
   assign preyx          = r_preyx;
   assign preyy          = r_preyy;
   assign score          = r_score;
   assign state          = r_state;
   assign game_won       = r_game_won;

endmodule

// File: tb/tb_snake_game_ctrl.sv
module tb_snake_game_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, pause, key_vld, frame_tick, snake_score, body_hit;
   logic [1:0] key_dir;
   logic [4:0] headx, heady;
   logic       body_rst, body_enb, body_valid, game_won;
   logic [1:0] body_direction;
   logic [4:0] preyx, preyy;
   logic [7:0] score;
   logic [2:0] state;

   int n_checks = 0;
   int n_err    = 0;
   int vcnt;
   logic [9:0] m_lfsr;

   always #5 clk = ~clk;

   snake_game_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .key_dir(key_dir), .key_vld(key_vld), .frame_tick(frame_tick),
      .snake_score(snake_score), .body_hit(body_hit),
      .snake_headx(headx), .snake_heady(heady),
      .body_rst(body_rst), .body_enb(body_enb), .body_valid(body_valid),
      .body_direction(body_direction), .preyx(preyx), .preyy(preyy),
      .score(score), .state(state), .game_won(game_won)
   );

   // Reference LFSR: 10-bit Fibonacci, taps 10 and 7, seed 2A5.
   always @(posedge clk) begin
      if (rst) m_lfsr <= 10'h2A5;
      else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
   end

   // Counts body_valid pulses seen on the bus.
   always @(posedge clk) begin
      if (rst)             vcnt <= 0;
      else if (body_valid) vcnt <= vcnt + 1;
   end

   function automatic int exp_period(input int sc);
`ifdef SNAKE_CTRL_SPEEDUP_EN
      int p;
      p = 8 - sc / 4;
      if (p < 2) p = 2;
      return p;
`else
      return 8 + 0 * sc;
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ftick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         ftick();
         cyc(9);
      end
   endtask

   task automatic eat();
      snake_score = 1'b1;
      cyc(1);
      snake_score = 1'b0;
   endtask

   task automatic key(input logic [1:0] d);
      key_dir = d;
      key_vld = 1'b1;
      cyc(1);
      key_vld = 1'b0;
   endtask

   task automatic ticks_to_valid(output int k);
      logic found;
      k = 0;
      found = 1'b0;
      while (!found && k < 16) begin
         ftick();
         k++;
         found = body_valid;
         cyc(9);
      end
   endtask

   task automatic wait_lfsr(input logic [9:0] mask, input logic [9:0] val);
      int k;
      k = 0;
      while (((m_lfsr & mask) != val) && k < 1100) begin
         cyc(1);
         k++;
      end
      chk("lfsr_wait", 32'(k < 1100), 1);
   endtask

   initial begin
      int ty[3];
      int ey[3];
      int v0, k, p;
      logic [4:0] ex, ly, cy;
      ty = '{27, 23, 24};
      ey = '{3, 23, 0};

      rst = 1'b1; start = 1'b0; pause = 1'b0; key_dir = 2'b00; key_vld = 1'b0;
      frame_tick = 1'b0; snake_score = 1'b0; body_hit = 1'b0;
      headx = 5'd0; heady = 5'd31;
      cyc(3);
      chk("rst_state", state, 0);
      chk("rst_body_rst", body_rst, 1);
      chk("rst_body_enb", body_enb, 0);
      chk("rst_body_valid", body_valid, 0);
      chk("rst_dir", body_direction, 1);
      chk("rst_preyx", preyx, 0);
      chk("rst_preyy", preyy, 0);
      chk("rst_score", score, 0);
      chk("rst_won", game_won, 0);
      rst = 1'b0;
      cyc(2);
      chk("idle_state", state, 0);
      chk("idle_body_rst", body_rst, 1);

      // Start: four INIT cycles with body_rst, then RUN.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("init_state", state, 1);
         chk("init_body_rst", body_rst, 1);
         cyc(1);
      end
      chk("run_state", state, 2);
      chk("run_body_rst", body_rst, 0);
      chk("run_body_enb", body_enb, 1);
      chk("init_preyx", preyx, 19);
      chk("init_preyy", preyy, 11);
      chk("init_dir", body_direction, 1);

      // First step: body_valid one cycle after the 8th tick.
      for (int i = 1; i <= 8; i++) begin
         ftick();
         chk("step1_valid", body_valid, (i == 8) ? 1 : 0);
         if (i == 8) chk("step1_dir", body_direction, 1);
         cyc(1);
         chk("step1_valid_off", body_valid, 0);
         cyc(8);
      end

      // LEFT is a reversal of RIGHT and is dropped, UP is taken.
      key(2'b10);
      key(2'b00);
      v0 = vcnt;
      ticks(7);
      chk("dir_hold_vcnt", vcnt, v0);
      chk("dir_hold", body_direction, 1);
      ftick();
      chk("step2_valid", body_valid, 1);
      chk("step2_dir", body_direction, 0);
      cyc(9);

      // Committed UP: DOWN dropped, RIGHT then LEFT taken (LEFT checked against UP).
      key(2'b11);
      key(2'b01);
      key(2'b10);
      ticks(7);
      ftick();
      chk("step3_valid", body_valid, 1);
      chk("step3_dir", body_direction, 2);
      cyc(9);

      // Prey placement with y folding.
      for (int i = 0; i < 3; i++) begin
         wait_lfsr(10'h01F, 10'(ty[i]));
         ex = m_lfsr[9:5];
         eat();
         chk("prey_x", preyx, ex);
         chk("prey_y", preyy, ey[i]);
         chk("prey_score", score, i + 1);
      end

      // Head collision with x=31 wraps to 0.
      wait_lfsr(10'h3E0, 10'(31 << 5));
      ly = m_lfsr[4:0];
      cy = (ly > 5'd23) ? ly - 5'd24 : ly;
      headx = 5'd31; heady = cy;
      eat();
      chk("prey_wrap_x", preyx, 0);
      chk("prey_wrap_y", preyy, cy);
      chk("prey_wrap_score", score, 4);

      // Head collision at x=5 moves to 6.
      wait_lfsr(10'h3E0, 10'(5 << 5));
      ly = m_lfsr[4:0];
      cy = (ly > 5'd23) ? ly - 5'd24 : ly;
      headx = 5'd5; heady = cy;
      eat();
      chk("prey_bump_x", preyx, 6);
      chk("prey_bump_score", score, 5);
      headx = 5'd0; heady = 5'd31;

      // Pause mid-step: counter frozen, keys still accepted.
      v0 = vcnt;
      ticks(3);
      pause = 1'b1;
      cyc(1);
      pause = 1'b0;
      chk("pause_state", state, 3);
      chk("pause_enb", body_enb, 0);
      ticks(20);
      chk("pause_vcnt", vcnt, v0);
      chk("pause_state_hold", state, 3);
      key(2'b00);
      pause = 1'b1;
      cyc(1);
      pause = 1'b0;
      chk("resume_state", state, 2);
      chk("resume_enb", body_enb, 1);
      ticks(4);
      chk("resume_vcnt", vcnt, v0);
      ftick();
      chk("resume_valid", body_valid, 1);
      chk("resume_dir", body_direction, 0);
      cyc(9);

      // Step spacing versus score.
      repeat (7) eat();
      chk("score12", score, 12);
      ticks_to_valid(k);
      ticks_to_valid(k);
      chk("spacing12", k, exp_period(12));
      repeat (28) eat();
      chk("score40", score, 40);
      ticks_to_valid(k);
      ticks_to_valid(k);
      chk("spacing40", k, exp_period(40));

      // Hit + score on the step-completing tick: score counts, OVER, no strobe.
      p = exp_period(40);
      ticks(p - 1);
      frame_tick = 1'b1; body_hit = 1'b1; snake_score = 1'b1;
      cyc(1);
      frame_tick = 1'b0; body_hit = 1'b0; snake_score = 1'b0;
      chk("over_state", state, 4);
      chk("over_score", score, 41);
      chk("over_enb", body_enb, 0);
      chk("over_valid", body_valid, 0);
      chk("over_won", game_won, 0);
      cyc(1);
      chk("over_valid_after", body_valid, 0);

      // Restart.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("restart_state", state, 1);
      chk("restart_body_rst", body_rst, 1);
      cyc(1);
      chk("restart_score", score, 0);
      chk("restart_dir", body_direction, 1);
      chk("restart_preyx", preyx, 19);
      cyc(3);
      chk("restart_run", state, 2);

      // pause together with body_hit goes to OVER; score ignored in OVER.
      pause = 1'b1; body_hit = 1'b1;
      cyc(1);
      pause = 1'b0; body_hit = 1'b0;
      chk("pause_hit_state", state, 4);
      eat();
      chk("over_eat_ignored", score, 0);

      // Win at SCORE_MAX.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(4);
      chk("win_run", state, 2);
      repeat (99) eat();
      chk("score99", score, 99);
      snake_score = 1'b1;
      cyc(1);
      chk("score100", score, 100);
      chk("score100_state", state, 2);
      chk("score100_won", game_won, 0);
      cyc(1);
      snake_score = 1'b0;
      chk("score_sat", score, 100);
      chk("win_state", state, 4);
      chk("win_flag", game_won, 1);

      // Reset mid-RUN discards a pending strobe.
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      cyc(4);
      chk("rst2_run", state, 2);
      chk("rst2_won_clr", game_won, 0);
      eat();
      eat();
      ticks(7);
      frame_tick = 1'b1; rst = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      chk("rst2_valid", body_valid, 0);
      chk("rst2_state", state, 0);
      chk("rst2_body_rst", body_rst, 1);
      chk("rst2_enb", body_enb, 0);
      chk("rst2_dir", body_direction, 1);
      chk("rst2_score", score, 0);
      chk("rst2_preyx", preyx, 0);
      chk("rst2_preyy", preyy, 0);
      rst = 1'b0;
      cyc(1);
      chk("rst2_valid_after", body_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
